complex_divider_seq: RTL and testbench

Sequential fixed-point complex divider, the inverse operation of the team's complex multiplier. It takes one complex dividend (a + jb) and one complex divisor (c + jd) per transaction over a valid/ready handshake. It returns (a + jb)/(c + jd) as signed fixed-point real and imaginary quotients with F fractional bits, using one shared FSM and two parallel restoring dividers. It sits downstream of equaliser/normalisation paths that undo a complex multiply.

---
 rtl/complex_divider_seq.sv | 203 ++++++++++++++++++++
 tb/tb_complex_divider_seq.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/complex_divider_seq.sv
// Sequential fixed-point complex divider: (a+jb)/(c+jd) -> Q(2N).F quotients.
// One shared FSM drives two restoring dividers (real and imaginary) in lockstep.
module complex_divider_seq #(
  parameter int unsigned N = 8,
  parameter int unsigned F = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [N-1:0]   real1,
  input  logic signed [N-1:0]   imag1,
  input  logic signed [N-1:0]   real2,
  input  logic signed [N-1:0]   imag2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [2*N+F:0] realo,
  output logic signed [2*N+F:0] imago,
  output logic                  div_zero
);

  localparam int unsigned W2 = 2 * N;
  localparam int unsigned M  = W2 + F;
  localparam int unsigned CW = $clog2(M + 1);

  typedef enum logic [2:0] {IDLE, PREP, DIV, FIN, DONE} state_t;

  state_t                state_q, state_d;
  logic signed [N-1:0]   a_q, b_q, c_q, d_q;
  logic signed [N-1:0]   a_d, b_d, c_d, d_d;
  logic [W2-1:0]         den_q, den_d;
  logic [M-1:0]          dvd_re_q, dvd_re_d, dvd_im_q, dvd_im_d;
  logic [W2-1:0]         rem_re_q, rem_re_d, rem_im_q, rem_im_d;
  logic [M-1:0]          quo_re_q, quo_re_d, quo_im_q, quo_im_d;
  logic                  neg_re_q, neg_re_d, neg_im_q, neg_im_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic                  div_zero_q, div_zero_d;
  logic signed [M:0]     realo_q, realo_d, imago_q, imago_d;

  // Cross products and denominator from the captured operands
  logic signed [W2-1:0]  ac_c, bd_c, bc_c, ad_c, cc_c, dd_c;
  logic signed [W2:0]    num_re_c, num_im_c;
  logic [W2-1:0]         den_c, mag_re_c, mag_im_c;
  logic [W2:0]           tr_re_c, tr_im_c;
  logic                  ge_re_c, ge_im_c;

  assign ac_c = W2'(a_q) * W2'(c_q);
  assign bd_c = W2'(b_q) * W2'(d_q);
  assign bc_c = W2'(b_q) * W2'(c_q);
  assign ad_c = W2'(a_q) * W2'(d_q);
  assign cc_c = W2'(c_q) * W2'(c_q);
  assign dd_c = W2'(d_q) * W2'(d_q);

  assign num_re_c = (W2+1)'(ac_c) + (W2+1)'(bd_c);
  assign num_im_c = (W2+1)'(bc_c) - (W2+1)'(ad_c);
  assign den_c    = W2'($unsigned(cc_c)) + W2'($unsigned(dd_c));
  assign mag_re_c = num_re_c[W2] ? W2'(-num_re_c) : W2'(num_re_c);
  assign mag_im_c = num_im_c[W2] ? W2'(-num_im_c) : W2'(num_im_c);

  // One restoring step per divider: shift in next dividend bit, trial-subtract den
  assign tr_re_c = {rem_re_q, dvd_re_q[M-1]};
  assign tr_im_c = {rem_im_q, dvd_im_q[M-1]};
  assign ge_re_c = (tr_re_c >= {1'b0, den_q});
  assign ge_im_c = (tr_im_c >= {1'b0, den_q});

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    d_d         = d_q;
    den_d       = den_q;
    dvd_re_d    = dvd_re_q;
    dvd_im_d    = dvd_im_q;
    rem_re_d    = rem_re_q;
    rem_im_d    = rem_im_q;
    quo_re_d    = quo_re_q;
    quo_im_d    = quo_im_q;
    neg_re_d    = neg_re_q;
    neg_im_d    = neg_im_q;
    cnt_d       = cnt_q;
    div_zero_d  = div_zero_q;
    realo_d     = realo_q;
    imago_d     = imago_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d        = real1;
          b_d        = imag1;
          c_d        = real2;
          d_d        = imag2;
          div_zero_d = 1'b0;
          state_d    = PREP;
        end
      end
      PREP: begin
        den_d    = den_c;
        dvd_re_d = {mag_re_c, {F{1'b0}}};
        dvd_im_d = {mag_im_c, {F{1'b0}}};
        neg_re_d = num_re_c[W2];
        neg_im_d = num_im_c[W2];
        rem_re_d = '0;
        rem_im_d = '0;
        quo_re_d = '0;
        quo_im_d = '0;
        cnt_d    = '0;
        if (den_c == '0) begin
          div_zero_d = 1'b1;
          realo_d    = '0;
          imago_d    = '0;
          state_d    = DONE;
        end else begin
          state_d = DIV;
        end
      end
      DIV: begin
        rem_re_d = ge_re_c ? W2'(tr_re_c - {1'b0, den_q}) : W2'(tr_re_c);
        rem_im_d = ge_im_c ? W2'(tr_im_c - {1'b0, den_q}) : W2'(tr_im_c);
        quo_re_d = {quo_re_q[M-2:0], ge_re_c};
        quo_im_d = {quo_im_q[M-2:0], ge_im_c};
        dvd_re_d = {dvd_re_q[M-2:0], 1'b0};
        dvd_im_d = {dvd_im_q[M-2:0], 1'b0};
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(M - 1)) begin
          state_d = FIN;
        end
      end
      FIN: begin
        realo_d = neg_re_q ? -$signed({1'b0, quo_re_q}) : $signed({1'b0, quo_re_q});
        imago_d = neg_im_q ? -$signed({1'b0, quo_im_q}) : $signed({1'b0, quo_im_q});
        state_d = DONE;
      end
      DONE: begin
        if (out_valid_q && out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers; ce freezes everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      den_q       <= '0;
      dvd_re_q    <= '0;
      dvd_im_q    <= '0;
      rem_re_q    <= '0;
      rem_im_q    <= '0;
      quo_re_q    <= '0;
      quo_im_q    <= '0;
      neg_re_q    <= 1'b0;
      neg_im_q    <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      div_zero_q  <= 1'b0;
      realo_q     <= '0;
      imago_q     <= '0;
    end else if (ce) begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      d_q         <= d_d;
      den_q       <= den_d;
      dvd_re_q    <= dvd_re_d;
      dvd_im_q    <= dvd_im_d;
      rem_re_q    <= rem_re_d;
      rem_im_q    <= rem_im_d;
      quo_re_q    <= quo_re_d;
      quo_im_q    <= quo_im_d;
      neg_re_q    <= neg_re_d;
      neg_im_q    <= neg_im_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      div_zero_q  <= div_zero_d;
      realo_q     <= realo_d;
      imago_q     <= imago_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign div_zero  = div_zero_q;
  assign realo     = realo_q;
  assign imago     = imago_q;

endmodule

// File: tb/tb_complex_divider_seq.sv
// Directed bench for complex_divider_seq with hand-computed quotients.
module tb_complex_divider_seq;

  logic               clk = 1'b0;
  logic               rst;
  logic               ce;
  logic               in_valid;
  logic               in_ready;
  logic signed [7:0]  real1, imag1, real2, imag2;
  logic               out_valid;
  logic               out_ready;
  logic signed [24:0] realo, imago;
  logic               div_zero;

  int checks   = 0;
  int failures = 0;

  complex_divider_seq #(.N(8), .F(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .real1     (real1),
    .imag1     (imag1),
    .real2     (real2),
    .imag2     (imag2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .realo     (realo),
    .imago     (imago),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one transaction, wait for out_valid (ce dropped for 5 edges from ce_at if >= 0)
  task automatic txn(input string tag,
                     input logic signed [7:0] a, input logic signed [7:0] b,
                     input logic signed [7:0] c, input logic signed [7:0] d,
                     input int exp_lat, input int ce_at,
                     input logic signed [31:0] er, input logic signed [31:0] ei,
                     input logic edz);
    int cyc;
    logic saw_ready;
    real1 = a; imag1 = b; real2 = c; imag2 = d;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    saw_ready = in_ready;
    while (!out_valid && cyc < 200) begin
      ce = (ce_at >= 0 && cyc >= ce_at && cyc < ce_at + 5) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      cyc++;
      if (!out_valid) saw_ready = saw_ready | in_ready;
    end
    ce = 1'b1;
    chk({tag, "_latency"}, cyc, exp_lat);
    chk({tag, "_realo"}, 32'(realo), er);
    chk({tag, "_imago"}, 32'(imago), ei);
    chk({tag, "_divzero"}, 32'(div_zero), 32'(edz));
    chk({tag, "_busy_ready"}, 32'(saw_ready), 0);
  endtask

  // One edge with out_ready high completes the output handshake
  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_drain_valid"}, 32'(out_valid), 0);
    chk({tag, "_drain_ready"}, 32'(in_ready), 1);
  endtask

  initial begin
    logic signed [24:0] hold_re;
    rst = 1'b1; ce = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    real1 = '0; imag1 = '0; real2 = '0; imag2 = '0;
    #2;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_realo", 32'(realo), 0);
    chk("rst_imago", 32'(imago), 0);
    chk("rst_divzero", 32'(div_zero), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    txn("t100", 8'sd100, 8'sd0, 8'sd10, 8'sd0, 26, -1, 2560, 0, 1'b0);
    drain("t100");
    txn("t34", 8'sd3, 8'sd4, 8'sd1, 8'sd2, 26, -1, 563, -102, 1'b0);
    drain("t34");
    txn("tneg", -8'sd128, -8'sd128, 8'sd0, 8'sd1, 26, -1, -32768, 32768, 1'b0);
    drain("tneg");
    txn("text", -8'sd128, -8'sd128, -8'sd128, 8'sd0, 26, -1, 256, 256, 1'b0);
    drain("text");
    txn("tdz", 8'sd5, 8'sd5, 8'sd0, 8'sd0, 1, -1, 0, 0, 1'b1);
    drain("tdz");
    txn("tafterdz", 8'sd4, 8'sd0, 8'sd2, 8'sd0, 26, -1, 512, 0, 1'b0);
    drain("tafterdz");

    // Backpressure: result must hold while out_ready is low
    out_ready = 1'b0;
    txn("tbp", 8'sd3, 8'sd4, 8'sd1, 8'sd2, 26, -1, 563, -102, 1'b0);
    hold_re = realo;
    repeat (10) @(posedge clk);
    #1;
    chk("bp_valid", 32'(out_valid), 1);
    chk("bp_ready", 32'(in_ready), 0);
    chk("bp_realo", 32'(realo), 32'(hold_re));
    chk("bp_imago", 32'(imago), -102);
    drain("tbp");

    // Clock enable low for 5 cycles mid-DIV stretches latency by 5
    txn("tce", 8'sd100, 8'sd0, 8'sd10, 8'sd0, 31, 10, 2560, 0, 1'b0);
    drain("tce");

    // Reset 10 cycles into a transaction aborts it
    real1 = 8'sd3; imag1 = 8'sd4; real2 = 8'sd1; imag2 = 8'sd2;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rstmid_in_ready", 32'(in_ready), 1);
    chk("rstmid_out_valid", 32'(out_valid), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("rstmid_no_partial", 32'(out_valid), 0);
    txn("tpost", -8'sd7, 8'sd3, 8'sd2, -8'sd1, 26, -1, -870, -51, 1'b0);
    drain("tpost");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
